// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture register for one fetched instruction while decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        valid
);

  // clear wins over load so a redirect always drops the held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= NOP_INSTR;
      valid <= 1'b0;
    end else if (clear) begin
      q     <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing: boot delay, imem req/ack handshake, decode-stall hold,
// branch redirect with squash of the in-flight fetch, and imem timeout.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned BOOT_HOLD   = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        pc_en,
  output logic        pc_src,
  output logic [31:0] branch_addr,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        ifid_flush,
  output logic        fetch_err
);

  fetch_state_e state;
  logic [3:0]   hold_cnt;
  logic [7:0]   to_cnt;
  logic         redirect_pend;
  logic [31:0]  redirect_tgt;

  logic         buf_load;
  logic         buf_clear;
  logic [31:0]  buf_q;
  logic         buf_valid;
  logic         acked;
  logic         redirect_now;

  assign mem_addr     = mem_req ? pc_current : '0;
  assign acked        = mem_req & mem_ack;
  assign redirect_now = redirect_pend | branch_taken;

  always_comb begin
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (state == ST_FETCH && acked && !redirect_now && stall)
      buf_load = 1'b1;
    if (state == ST_HOLD && (branch_taken || !stall))
      buf_clear = 1'b1;
  end

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst_n (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .d     (mem_rdata),
    .q     (buf_q),
    .valid (buf_valid)
  );

  // FETCH has an internal gap phase (mem_req=0) covering the cycle in which
  // the PC register absorbs the pc_en pulse; the request is re-raised after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_BOOT;
      hold_cnt      <= 4'(BOOT_HOLD);
      to_cnt        <= '0;
      redirect_pend <= 1'b0;
      redirect_tgt  <= '0;
      mem_req       <= 1'b0;
      pc_en         <= 1'b0;
      pc_src        <= 1'b0;
      branch_addr   <= '0;
      instr_out     <= NOP_INSTR;
      instr_valid   <= 1'b0;
      ifid_flush    <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      pc_en       <= 1'b0;
      pc_src      <= 1'b0;
      instr_valid <= 1'b0;
      ifid_flush  <= 1'b0;
      instr_out   <= NOP_INSTR;

      case (state)
        ST_BOOT: begin
          if (hold_cnt == '0) begin
            state   <= ST_FETCH;
            mem_req <= 1'b1;
            to_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end

        ST_FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            to_cnt  <= '0;
            if (branch_taken) begin
              redirect_pend <= 1'b1;
              redirect_tgt  <= branch_target;
            end
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            to_cnt  <= '0;
            if (redirect_now) begin
              pc_en         <= 1'b1;
              pc_src        <= 1'b1;
              ifid_flush    <= 1'b1;
              branch_addr   <= branch_taken ? branch_target : redirect_tgt;
              redirect_pend <= 1'b0;
            end else if (!stall) begin
              instr_out   <= mem_rdata;
              instr_valid <= 1'b1;
              pc_en       <= 1'b1;
            end else begin
              state <= ST_HOLD;
            end
          end else begin
            if (branch_taken) begin
              redirect_pend <= 1'b1;
              redirect_tgt  <= branch_target;
            end
            if (to_cnt == 8'(MEM_TIMEOUT - 1)) begin
              state     <= ST_ERR;
              mem_req   <= 1'b0;
              fetch_err <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end
        end

        ST_HOLD: begin
          mem_req <= 1'b0;
          if (branch_taken) begin
            pc_en       <= 1'b1;
            pc_src      <= 1'b1;
            ifid_flush  <= 1'b1;
            branch_addr <= branch_target;
            state       <= ST_FETCH;
          end else if (!stall) begin
            instr_out   <= buf_q;
            instr_valid <= buf_valid;
            pc_en       <= 1'b1;
            state       <= ST_FETCH;
          end
        end

        ST_ERR: begin
          mem_req   <= 1'b0;
          fetch_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register in the loop.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        pc_en;
  logic        pc_src;
  logic [31:0] branch_addr;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        ifid_flush;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.BOOT_HOLD(2), .MEM_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .branch_addr   (branch_addr),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .ifid_flush    (ifid_flush),
    .fetch_err     (fetch_err)
  );

  // PC register + next-PC mux of the fetch datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pc_current <= '0;
    else if (pc_en) pc_current <= pc_src ? branch_addr : pc_current + PC_STEP;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk1 ("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1 ("rst_pc_en", pc_en, 1'b0);
    chk1 ("rst_instr_valid", instr_valid, 1'b0);
    chk1 ("rst_flush", ifid_flush, 1'b0);
    chk1 ("rst_err", fetch_err, 1'b0);
    chk32("rst_instr_out", instr_out, 32'h0);
    chk32("rst_branch_addr", branch_addr, 32'h0);

    // boot: first request on the third edge after release
    reset = 1'b1;
    step(); chk1("boot_c1_req", mem_req, 1'b0);
    step(); chk1("boot_c2_req", mem_req, 1'b0);
    step(); chk1("boot_c3_req", mem_req, 1'b1);
    chk32("boot_addr", mem_addr, 32'h0);

    // latency-1 fetch
    mem_ack = 1'b1; mem_rdata = 32'h1111_0001;
    step(); mem_ack = 1'b0;
    chk1 ("f1_valid", instr_valid, 1'b1);
    chk32("f1_instr", instr_out, 32'h1111_0001);
    chk1 ("f1_pc_en", pc_en, 1'b1);
    chk1 ("f1_pc_src", pc_src, 1'b0);
    chk1 ("f1_gap_req", mem_req, 1'b0);
    step();
    chk1 ("f1_rereq", mem_req, 1'b1);
    chk32("f1_addr", mem_addr, 32'h4);
    chk1 ("f1_valid_pulse", instr_valid, 1'b0);
    chk1 ("f1_pc_en_pulse", pc_en, 1'b0);

    // stall across ack -> hold, stall held for 3 edges
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h2002_0005;
    step(); mem_ack = 1'b0;
    chk1 ("hold_req", mem_req, 1'b0);
    chk1 ("hold_valid", instr_valid, 1'b0);
    chk1 ("hold_pc_en", pc_en, 1'b0);
    step(); chk32("hold_pc_frozen1", pc_current, 32'h4);
    step(); chk32("hold_pc_frozen2", pc_current, 32'h4);
    chk1("hold_req2", mem_req, 1'b0);
    stall = 1'b0;
    step();
    chk1 ("rel_valid", instr_valid, 1'b1);
    chk32("rel_instr", instr_out, 32'h2002_0005);
    chk1 ("rel_pc_en", pc_en, 1'b1);
    chk1 ("rel_pc_src", pc_src, 1'b0);
    step();
    chk1 ("rel_pc_en_once", pc_en, 1'b0);
    chk32("rel_addr", mem_addr, 32'h8);

    // branch one cycle before ack
    branch_taken = 1'b1; branch_target = 32'h40;
    step(); branch_taken = 1'b0; branch_target = '0;
    chk1("br_no_flush_yet", ifid_flush, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(); mem_ack = 1'b0;
    chk1 ("br_flush", ifid_flush, 1'b1);
    chk1 ("br_pc_src", pc_src, 1'b1);
    chk1 ("br_pc_en", pc_en, 1'b1);
    chk32("br_addr", branch_addr, 32'h40);
    chk1 ("br_no_valid", instr_valid, 1'b0);
    chk32("br_instr_nop", instr_out, 32'h0);
    step();
    chk1 ("br_flush_pulse", ifid_flush, 1'b0);
    chk32("br_next_addr", mem_addr, 32'h40);

    // branch in the same cycle as ack
    branch_taken = 1'b1; branch_target = 32'h80; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step(); branch_taken = 1'b0; mem_ack = 1'b0;
    chk1 ("sbr_flush", ifid_flush, 1'b1);
    chk32("sbr_addr", branch_addr, 32'h80);
    chk1 ("sbr_no_valid", instr_valid, 1'b0);
    step();
    chk32("sbr_next_addr", mem_addr, 32'h80);

    // branch + stall together while holding
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    step(); mem_ack = 1'b0;
    chk1("hb_hold", mem_req, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h100;
    step(); branch_taken = 1'b0; stall = 1'b0;
    chk1 ("hb_flush", ifid_flush, 1'b1);
    chk1 ("hb_pc_en", pc_en, 1'b1);
    chk1 ("hb_pc_src", pc_src, 1'b1);
    chk32("hb_addr", branch_addr, 32'h100);
    chk1 ("hb_no_valid", instr_valid, 1'b0);
    step();
    chk1 ("hb_dropped", instr_valid, 1'b0);
    chk32("hb_next_addr", mem_addr, 32'h100);

    // latency-2 fetch
    step();
    chk1("l2_wait_req", mem_req, 1'b1);
    chk1("l2_wait_valid", instr_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step(); mem_ack = 1'b0;
    chk1 ("l2_valid", instr_valid, 1'b1);
    chk32("l2_instr", instr_out, 32'h0BAD_F00D);
    step();
    chk32("l2_next_addr", mem_addr, 32'h104);

    // timeout: 16 request cycles without ack
    for (int i = 0; i < 15; i++) step();
    chk1("to_req_15", mem_req, 1'b1);
    chk1("to_err_15", fetch_err, 1'b0);
    step();
    chk1("to_err", fetch_err, 1'b1);
    chk1("to_req_drop", mem_req, 1'b0);
    mem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    step(); step(); step();
    mem_ack = 1'b0; branch_taken = 1'b0;
    chk1("err_sticky", fetch_err, 1'b1);
    chk1("err_req", mem_req, 1'b0);
    chk1("err_pc_en", pc_en, 1'b0);
    chk1("err_valid", instr_valid, 1'b0);

    // reset clears the error and restarts the boot sequence
    reset = 1'b0; #1;
    chk1("err_rst_clear", fetch_err, 1'b0);
    step(); reset = 1'b1;
    step(); step(); step();
    chk1 ("rb_req", mem_req, 1'b1);
    chk32("rb_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_0001;
    step(); mem_ack = 1'b0;
    chk32("rb_instr", instr_out, 32'h7777_0001);
    step();
    chk32("rb_next_addr", mem_addr, 32'h4);

    // reset mid-fetch with ack arriving during and after reset
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    reset = 1'b0; #1;
    chk1 ("mr_req", mem_req, 1'b0);
    chk32("mr_addr", mem_addr, 32'h0);
    chk1 ("mr_valid", instr_valid, 1'b0);
    step(); step();
    chk1 ("mr_valid2", instr_valid, 1'b0);
    chk32("mr_instr", instr_out, 32'h0);
    reset = 1'b1;
    step();
    chk1("mr_boot1_valid", instr_valid, 1'b0);
    chk1("mr_boot1_req", mem_req, 1'b0);
    step();
    chk1("mr_boot2_valid", instr_valid, 1'b0);
    mem_ack = 1'b0;
    step();
    chk1 ("mr_restart_req", mem_req, 1'b1);
    chk32("mr_restart_addr", mem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
